register_file: RTL and testbench

//   32-entry MIPS general-purpose register file for the single-cycle datapath.
//   Two combinational read ports drive the ALU A operand and the B-mux.
//   One clocked write port takes write-back data (ALU result or memory data).
//   $zero is hard-wired to 0; $gp and $sp come up at reset with MIPS defaults.

---
 rtl/register_file_if.sv | 33 +++
 rtl/register_file.sv | 65 ++++++
 tb/tb_register_file.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - read/write port bundle for the MIPS register file
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    modport master (
        output read_reg1,
        output read_reg2,
        output write_reg,
        output write_data,
        output reg_write,
        input  read_data1,
        input  read_data2
    );

    modport slave (
        input  read_reg1,
        input  read_reg2,
        input  write_reg,
        input  write_data,
        input  reg_write,
        output read_data1,
        output read_data2
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32-entry MIPS GPR file, 2 comb read ports, 1 clocked write port
// Optional feature macro: REGFILE_WRITE_BYPASS_EN (write-before-read forwarding)
module register_file #(
    parameter int              DATA_W  = 32,
    parameter int              ADDR_W  = 5,
    parameter logic [DATA_W-1:0] GP_INIT = 32'h10008000,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h7FFFEFFC
) (
    input  logic          clk,
    input  logic          rst,
    register_file_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int GP_IDX = 28;
    localparam int SP_IDX = 29;

    // Entry 0 ($zero) has no storage; reads of index 0 are forced to zero.
    logic [DATA_W-1:0] r_regs [1:DEPTH-1];

    logic w_wr_en;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_wr_en = !rst && bus.reg_write && (bus.write_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (i == GP_IDX)
                    r_regs[i] <= GP_INIT;
                else if (i == SP_IDX)
                    r_regs[i] <= SP_INIT;
                else
                    r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[bus.write_reg] <= bus.write_data;
        end
    end

    always_comb begin
        w_rd1 = '0;
        if (bus.read_reg1 != '0) begin
            w_rd1 = r_regs[bus.read_reg1];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (w_wr_en && (bus.write_reg == bus.read_reg1))
                w_rd1 = bus.write_data;
`endif
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (bus.read_reg2 != '0) begin
            w_rd2 = r_regs[bus.read_reg2];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (w_wr_en && (bus.write_reg == bus.read_reg2))
                w_rd2 = bus.write_data;
`endif
        end
    end

    assign bus.read_data1 = w_rd1;
    assign bus.read_data2 = w_rd2;
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;
    localparam logic [31:0] GP = 32'h10008000;
    localparam logic [31:0] SP = 32'h7FFFEFFC;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    register_file #(
        .DATA_W (32),
        .ADDR_W (5),
        .GP_INIT(GP),
        .SP_INIT(SP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        bus.reg_write  = 1'b1;
        bus.write_reg  = idx;
        bus.write_data = data;
        tick();
        bus.reg_write  = 1'b0;
    endtask

    task automatic read_both(input logic [4:0] a, input logic [4:0] b);
        bus.read_reg1 = a;
        bus.read_reg2 = b;
        #1;
    endtask

    function automatic logic [31:0] reset_val(input int idx);
        if (idx == 28) return GP;
        if (idx == 29) return SP;
        return 32'h0;
    endfunction

    initial begin
        n_total = 0;
        n_bad   = 0;
        bus.read_reg1  = '0;
        bus.read_reg2  = '0;
        bus.write_reg  = '0;
        bus.write_data = '0;
        bus.reg_write  = 1'b0;

        // Reset with a competing write: write must be dropped.
        rst = 1'b1;
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd5;
        bus.write_data = 32'h1;
        tick();
        rst = 1'b0;
        bus.reg_write = 1'b0;

        for (int i = 0; i < 32; i++) begin
            read_both(5'(i), 5'(31 - i));
            check_eq($sformatf("rst_p1_r%0d", i), bus.read_data1, reset_val(i));
            check_eq($sformatf("rst_p2_r%0d", 31 - i), bus.read_data2, reset_val(31 - i));
        end

        write_reg(5'd8, 32'hDEADBEEF);
        read_both(5'd8, 5'd8);
        check_eq("wr8_p1", bus.read_data1, 32'hDEADBEEF);
        check_eq("wr8_p2", bus.read_data2, 32'hDEADBEEF);

        // Write to $zero: ignored in both builds, even during the write cycle.
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd0;
        bus.write_data = 32'hFFFFFFFF;
        read_both(5'd0, 5'd8);
        check_eq("wr0_during", bus.read_data1, 32'h0);
        tick();
        bus.reg_write = 1'b0;
        read_both(5'd0, 5'd0);
        check_eq("wr0_after_p1", bus.read_data1, 32'h0);
        check_eq("wr0_after_p2", bus.read_data2, 32'h0);

        write_reg(5'd31, 32'hCAFEF00D);
        read_both(5'd31, 5'd8);
        check_eq("wr31_p1", bus.read_data1, 32'hCAFEF00D);
        check_eq("wr31_keep8", bus.read_data2, 32'hDEADBEEF);

        // Read-during-write on r9.
        write_reg(5'd9, 32'h1);
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd9;
        bus.write_data = 32'h2;
        read_both(5'd8, 5'd9);
`ifdef REGFILE_WRITE_BYPASS_EN
        check_eq("rdw_r9_p2", bus.read_data2, 32'h2);
`else
        check_eq("rdw_r9_p2", bus.read_data2, 32'h1);
`endif
        check_eq("rdw_other_p1", bus.read_data1, 32'hDEADBEEF);
        tick();
        bus.reg_write = 1'b0;
        read_both(5'd9, 5'd9);
        check_eq("rdw_r9_after_p1", bus.read_data1, 32'h2);
        check_eq("rdw_r9_after_p2", bus.read_data2, 32'h2);

        // reg_write=0 holds r10 for several cycles.
        write_reg(5'd10, 32'h00000055);
        bus.reg_write  = 1'b0;
        bus.write_reg  = 5'd10;
        bus.write_data = 32'h1234;
        tick();
        tick();
        tick();
        read_both(5'd10, 5'd10);
        check_eq("nowe_r10_p1", bus.read_data1, 32'h00000055);
        check_eq("nowe_r10_p2", bus.read_data2, 32'h00000055);

        // Mid-program reset with a competing write of r5.
        write_reg(5'd5, 32'hA5A5A5A5);
        write_reg(5'd28, 32'h00001234);
        read_both(5'd5, 5'd28);
        check_eq("pre_rst_r5", bus.read_data1, 32'hA5A5A5A5);
        check_eq("pre_rst_r28", bus.read_data2, 32'h00001234);
        rst = 1'b1;
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd5;
        bus.write_data = 32'h1;
        read_both(5'd5, 5'd5);
        check_eq("rst_asserted_r5", bus.read_data1, 32'hA5A5A5A5);
        tick();
        read_both(5'd5, 5'd29);
        check_eq("rst2_r5", bus.read_data1, 32'h0);
        check_eq("rst2_r29", bus.read_data2, SP);
        read_both(5'd28, 5'd8);
        check_eq("rst2_r28", bus.read_data1, GP);
        check_eq("rst2_r8", bus.read_data2, 32'h0);

        tick();
        tick();
        rst = 1'b0;
        bus.reg_write = 1'b0;
        read_both(5'd5, 5'd31);
        check_eq("rst_hold_r5", bus.read_data1, 32'h0);
        check_eq("rst_hold_r31", bus.read_data2, 32'h0);
        read_both(5'd28, 5'd29);
        check_eq("rst_hold_r28", bus.read_data1, GP);
        check_eq("rst_hold_r29", bus.read_data2, SP);

        write_reg(5'd1, 32'h13579BDF);
        read_both(5'd1, 5'd2);
        check_eq("post_rst_r1", bus.read_data1, 32'h13579BDF);
        check_eq("post_rst_r2", bus.read_data2, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
